rc_channel_filter: RTL and testbench

Per-channel conditioning stage placed directly downstream of `pwm_decode`. It consumes the decoded pulse-width strobe and value and range-checks each sample against the RC window. It produces a 4-sample moving average with deadband hysteresis and a failsafe output for the flight logic. It also detects loss of signal and runs of out-of-range pulses, forcing a fixed failsafe value until the channel has recovered.

---
 rtl/rc_channel_filter.sv | 159 +++++++++++++++
 tb/tb_rc_channel_filter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_channel_filter.sv
// RC channel conditioner: range check, 4-sample mean with deadband, loss-of-signal failsafe.
// Latency: o_reject 1 edge, o_valid 2 edges after strobe; no backpressure, a strobe every cycle is taken.
module rc_channel_filter #(
   parameter int unsigned MIN_US         = 1000,
   parameter int unsigned MAX_US         = 2000,
   parameter int unsigned DEADBAND       = 3,
   parameter int unsigned REJECT_LIMIT   = 3,
   parameter int unsigned TIMEOUT_CYCLES = 2500000,
   parameter int unsigned FAILSAFE_VALUE = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_sample_valid,
   input  logic [15:0] i_sample,
   output logic [15:0] o_value,
   output logic        o_valid,
   output logic        o_failsafe,
   output logic        o_reject
);

   localparam logic [15:0] MIN_V = 16'(MIN_US);
   localparam logic [15:0] MAX_V = 16'(MAX_US);
   localparam logic [16:0] DB_V  = 17'(DEADBAND);
   localparam logic [7:0]  REJ_V = 8'(REJECT_LIMIT);
   localparam logic [31:0] TMO_V = 32'(TIMEOUT_CYCLES);
   localparam logic [15:0] FS_V  = 16'(FAILSAFE_VALUE);

   typedef enum logic {
      ST_FAILSAFE = 1'b0,
      ST_RUN      = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [3:0][15:0] hist_q, hist_d;
   logic             acc_q, acc_d;
   logic             done_q, done_d;
   logic             reject_q, reject_d;
   logic [7:0]       rej_cnt_q, rej_cnt_d;
   logic [1:0]       fill_q, fill_d;
   logic [31:0]      tmo_q, tmo_d;
   logic [15:0]      value_q, value_d;
   logic             valid_q, valid_d;

   logic             accept;
   logic             reject;
   logic             rej_hit;
   logic             tmo_hit;
   logic             fs_enter;
   logic             db_hit;
   logic [17:0]      sum;
   logic [15:0]      mean;
   logic signed [16:0] diff;
   logic [16:0]      mag;

   assign accept = i_sample_valid && (i_sample >= MIN_V) && (i_sample <= MAX_V);
   assign reject = i_sample_valid && !accept;

   // Stage 1: history, reject/timeout counters and fill tracking.
   always_comb begin
      hist_d    = hist_q;
      rej_cnt_d = rej_cnt_q;
      fill_d    = fill_q;
      done_d    = 1'b0;
      acc_d     = accept;
      reject_d  = reject;
      tmo_d     = (state_q == ST_RUN) ? tmo_q + 32'd1 : 32'd0;

      if (accept) begin
         hist_d    = {hist_q[2:0], i_sample};
         rej_cnt_d = 8'd0;
         tmo_d     = 32'd0;
      end else if (reject && rej_cnt_q < REJ_V) begin
         rej_cnt_d = rej_cnt_q + 8'd1;
      end

      if (state_q == ST_RUN) begin
         fill_d = 2'd0;
      end else if (accept) begin
         if (fill_q == 2'd3) begin
            fill_d = 2'd0;
            done_d = 1'b1;
         end else begin
            fill_d = fill_q + 2'd1;
         end
      end else if (reject) begin
         fill_d = 2'd0;
      end
   end

   // Stage 2 datapath: mean of the history written on the previous edge.
   always_comb begin
      sum  = 18'(hist_q[0]) + 18'(hist_q[1]) + 18'(hist_q[2]) + 18'(hist_q[3]);
      mean = 16'(sum >> 2);
      diff = $signed({1'b0, mean}) - $signed({1'b0, value_q});
      mag  = diff[16] ? -diff : diff;
   end

   assign db_hit  = (mag >= DB_V);
   assign rej_hit = (rej_cnt_q == REJ_V);
   // A sample accepted on the expiry edge clears the counter, so it beats the timeout.
   assign tmo_hit = !accept && ((tmo_q + 32'd1) >= TMO_V);
   assign fs_enter = (state_q == ST_RUN) && (rej_hit || tmo_hit);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FAILSAFE: if (done_q)   state_d = ST_RUN;
         ST_RUN:      if (fs_enter) state_d = ST_FAILSAFE;
         default:     state_d = ST_FAILSAFE;
      endcase
   end

   always_comb begin
      value_d = value_q;
      valid_d = 1'b0;
      if (fs_enter) begin
         value_d = FS_V;
         valid_d = 1'b1;
      end else if (state_q == ST_FAILSAFE && done_q) begin
         value_d = mean;
         valid_d = 1'b1;
      end else if (state_q == ST_RUN && acc_q && db_hit) begin
         value_d = mean;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FAILSAFE;
         hist_q    <= '0;
         acc_q     <= 1'b0;
         done_q    <= 1'b0;
         reject_q  <= 1'b0;
         rej_cnt_q <= 8'd0;
         fill_q    <= 2'd0;
         tmo_q     <= 32'd0;
         value_q   <= FS_V;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         acc_q     <= acc_d;
         done_q    <= done_d;
         reject_q  <= reject_d;
         rej_cnt_q <= rej_cnt_d;
         fill_q    <= fill_d;
         tmo_q     <= tmo_d;
         value_q   <= value_d;
         valid_q   <= valid_d;
      end
   end

   assign o_value    = value_q;
   assign o_valid    = valid_q;
   assign o_failsafe = (state_q == ST_FAILSAFE);
   assign o_reject   = reject_q;

endmodule

// File: tb/tb_rc_channel_filter.sv
// Bench for rc_channel_filter: directed scenarios plus random traffic against a queue-based model.
module tb_rc_channel_filter;

   localparam int TMO = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        i_sample_valid = 1'b0;
   logic [15:0] i_sample = 16'd0;
   logic [15:0] o_value;
   logic        o_valid;
   logic        o_failsafe;
   logic        o_reject;

   rc_channel_filter #(
      .MIN_US(1000), .MAX_US(2000), .DEADBAND(3), .REJECT_LIMIT(3),
      .TIMEOUT_CYCLES(TMO), .FAILSAFE_VALUE(1000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_sample_valid(i_sample_valid), .i_sample(i_sample),
      .o_value(o_value), .o_valid(o_valid), .o_failsafe(o_failsafe), .o_reject(o_reject)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int edge_n;
      int value;
      bit fs;
   } vexp_t;

   vexp_t vq[$];
   int    rq[$];

   // Reference model state: history as a list of the last four accepted widths.
   int mh[$];
   bit m_run;
   int m_fill, m_rejc, m_tmo, m_val;
   bit m_pend, m_done;

   task automatic model_reset();
      mh = '{0, 0, 0, 0};
      m_run = 0; m_fill = 0; m_rejc = 0; m_tmo = 0; m_val = 1000;
      m_pend = 0; m_done = 0;
      vq.delete();
      rq.delete();
   endtask

   task automatic push_v(int e, int v, bit fs);
      vexp_t x;
      x.edge_n = e; x.value = v; x.fs = fs;
      vq.push_back(x);
   endtask

   task automatic model_edge(bit sv, int s, int e);
      bit acc, rej, run_old;
      int mean, d;
      acc = sv && s >= 1000 && s <= 2000;
      rej = sv && !acc;
      run_old = m_run;
      mean = (mh[0] + mh[1] + mh[2] + mh[3]) / 4;
      d = mean - m_val;
      if (d < 0) d = -d;
      if (m_run && (m_rejc >= 3 || (!acc && m_tmo + 1 >= TMO))) begin
         m_run = 0; m_val = 1000; m_fill = 0;
         push_v(e, 1000, 1);
      end else if (!m_run && m_done) begin
         m_run = 1; m_val = mean;
         push_v(e, mean, 0);
      end else if (m_run && m_pend && d >= 3) begin
         m_val = mean;
         push_v(e, mean, 0);
      end
      if (acc) begin
         mh.push_front(s);
         void'(mh.pop_back());
         m_rejc = 0;
         m_tmo = 0;
      end else begin
         m_tmo = run_old ? m_tmo + 1 : 0;
      end
      if (rej) begin
         rq.push_back(e);
         if (m_rejc < 3) m_rejc++;
      end
      m_done = 0;
      if (run_old) m_fill = 0;
      else if (acc) begin
         m_fill++;
         if (m_fill == 4) begin m_fill = 0; m_done = 1; end
      end else if (rej) m_fill = 0;
      m_pend = acc;
   endtask

   task automatic step(bit sv, int s);
      @(negedge clk);
      i_sample_valid = sv;
      i_sample = 16'(s);
      model_edge(sv, s, cyc + 1);
   endtask

   task automatic idle(int n);
      repeat (n) step(0, 0);
   endtask

   task automatic chk(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every output pulse must match the oldest expectation, edge included.
   always @(negedge clk) begin
      vexp_t e;
      int r;
      if (rst_n) begin
         if (o_valid) begin
            checks++;
            if (vq.size() == 0) begin
               errors++;
               $display("FAIL valid_out: unexpected pulse at edge %0d value %0d", cyc, o_value);
            end else begin
               e = vq.pop_front();
               if (e.edge_n != cyc || e.value != int'(o_value) || e.fs != o_failsafe) begin
                  errors++;
                  $display("FAIL valid_out: got edge %0d value %0d fs %0d, expected edge %0d value %0d fs %0d",
                           cyc, o_value, o_failsafe, e.edge_n, e.value, e.fs);
               end
            end
         end
         if (o_reject) begin
            checks++;
            if (rq.size() == 0) begin
               errors++;
               $display("FAIL reject_out: unexpected pulse at edge %0d", cyc);
            end else begin
               r = rq.pop_front();
               if (r != cyc) begin
                  errors++;
                  $display("FAIL reject_out: got edge %0d expected edge %0d", cyc, r);
               end
            end
         end
      end
   end

   initial begin
      int c, r, bvals[4];
      bvals = '{999, 1000, 2000, 2001};
      model_reset();
      #1 rst_n = 1'b0;
      #1;
      chk("reset_value", o_value, 1000);
      chk("reset_failsafe", o_failsafe, 1);
      chk("reset_valid", o_valid, 0);
      chk("reset_reject", o_reject, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Startup fill
      repeat (4) step(1, 1500);
      idle(1);
      chk("fill_latency_fs", o_failsafe, 1);
      idle(1);
      chk("fill_value", o_value, 1500);
      chk("fill_failsafe", o_failsafe, 0);

      // Deadband
      step(1, 1502); idle(2);
      chk("deadband_hold", o_value, 1500);
      step(1, 1520); idle(2);
      chk("deadband_update", o_value, 1505);

      // Range and reject limit
      step(1, 999); step(1, 2001); idle(2);
      chk("reject_value_kept", o_value, 1505);
      step(1, 1505);
      step(1, 2500); step(1, 1500); step(1, 2500); step(1, 2500); idle(2);
      chk("reject_interrupted", o_failsafe, 0);
      step(1, 1500);
      repeat (3) step(1, 2500);
      idle(1);
      chk("reject_latency", o_failsafe, 0);
      idle(1);
      chk("reject_failsafe", o_failsafe, 1);
      chk("reject_fs_value", o_value, 1000);

      // Recovery restarts the fill after a reject
      step(1, 1500); step(1, 1500); step(1, 999);
      repeat (3) step(1, 1500);
      idle(2);
      chk("refill_incomplete", o_failsafe, 1);
      step(1, 1500); idle(2);
      chk("refill_done", o_failsafe, 0);
      chk("refill_value", o_value, 1500);

      // Timeout: an accept on the expiry edge wins, then full silence expires
      step(1, 1500); idle(99); step(1, 1500); idle(1);
      chk("tmo_priority", o_failsafe, 0);
      step(1, 1500); idle(100);
      chk("tmo_edge99", o_failsafe, 0);
      idle(1);
      chk("tmo_edge100", o_failsafe, 1);
      chk("tmo_value", o_value, 1000);

      // Boundaries
      repeat (4) step(1, 2000);
      idle(2);
      chk("max_mean", o_value, 2000);
      step(1, 1000); step(1, 1000); step(1, 1000);
      chk("step_1750", o_value, 1750);
      step(1, 1000);
      chk("step_1500", o_value, 1500);
      idle(1);
      chk("step_1250", o_value, 1250);
      idle(1);
      chk("step_1000", o_value, 1000);
      idle(102);
      chk("bound_fs", o_failsafe, 1);
      repeat (4) step(1, 1000);
      idle(2);
      chk("min_mean_fs", o_failsafe, 0);
      chk("min_mean", o_value, 1000);

      // Async reset mid-stream with a strobe in the reset cycle
      step(1, 1600); step(1, 1700);
      @(negedge clk);
      i_sample_valid = 1'b1;
      i_sample = 16'd1800;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_failsafe", o_failsafe, 1);
      chk("arst_value", o_value, 1000);
      chk("arst_valid", o_valid, 0);
      model_reset();
      @(negedge clk);
      chk("arst_hold_valid", o_valid, 0);
      chk("arst_hold_reject", o_reject, 0);
      rst_n = 1'b1;
      i_sample_valid = 1'b1;
      i_sample = 16'd1500;
      model_edge(1, 1500, cyc + 1);
      repeat (3) step(1, 1500);
      idle(2);
      chk("post_reset_run", o_failsafe, 0);
      chk("post_reset_value", o_value, 1500);

      // Random traffic
      c = 1500;
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) c = $urandom_range(1050, 1950);
         r = $urandom_range(0, 199);
         if (r < 2) idle($urandom_range(95, 110));
         else if (r < 60) step(0, 0);
         else if (r < 170) step(1, c + $urandom_range(0, 24) - 12);
         else if (r < 190) step(1, bvals[$urandom_range(0, 3)]);
         else if (r < 195) step(1, $urandom_range(0, 998));
         else step(1, $urandom_range(2002, 65535));
      end
      idle(3);
      chk("valid_queue_drained", vq.size(), 0);
      chk("reject_queue_drained", rq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
